readout_sequencer_verifla: RTL

- Top-level readout controller between the capture engine and the single shared UART transmitter.
- When a capture completes, sends a header frame: a magic octet, then the trigger/tail address LSB first.
- Then starts the capture sender through its run/ack handshake and grants it the transmitter until it signals done.
- Finally sends a trailer octet, pulses readout_done and waits for capture_done to clear before re-arming.

---
 rtl/readout_sequencer_verifla_pkg.sv | 22 ++
 rtl/readout_sequencer_verifla.sv | 109 ++++++++++
 2 files changed

// File: rtl/readout_sequencer_verifla_pkg.sv
// Shared constants and state encodings for the logic-analyser readout sequencer,
// so the RTL, the host-side decoder and the bench all agree on one definition.
package readout_sequencer_verifla_pkg;

  localparam int         LA_MEM_ADDRESS_BITS = 10;
  localparam int         ADDR_OCTETS         = 2;
  localparam logic [7:0] HDR_MAGIC           = 8'hA5;
  localparam logic [7:0] TRL_MAGIC           = 8'h5A;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_HDR_SEND = 4'd1,
    ST_HDR_WAIT = 4'd2,
    ST_SC_START = 4'd3,
    ST_SC_RUN   = 4'd4,
    ST_TRL_SEND = 4'd5,
    ST_TRL_WAIT = 4'd6,
    ST_DONE     = 4'd7,
    ST_WAIT_CLR = 4'd8
  } state_t;

endpackage

// File: rtl/readout_sequencer_verifla.sv
// Readout controller: owns the shared UART, frames each capture with a header
// (magic + tail address) and a trailer, and lends the UART to the capture sender.
module readout_sequencer_verifla #(
  parameter int         LA_MEM_ADDRESS_BITS = readout_sequencer_verifla_pkg::LA_MEM_ADDRESS_BITS,
  parameter int         ADDR_OCTETS         = readout_sequencer_verifla_pkg::ADDR_OCTETS,
  parameter logic [7:0] HDR_MAGIC           = readout_sequencer_verifla_pkg::HDR_MAGIC,
  parameter logic [7:0] TRL_MAGIC           = readout_sequencer_verifla_pkg::TRL_MAGIC
) (
  input  logic                           clk,
  input  logic                           rst_l,
  input  logic                           baud_clk_posedge,
  input  logic                           capture_done,
  input  logic [LA_MEM_ADDRESS_BITS-1:0] tail_address,
  output logic                           sc_run,
  input  logic                           ack_sc_run,
  input  logic                           sc_done,
  input  logic                           sc_xmitH,
  input  logic [7:0]                     sc_xmit_dataH,
  output logic                           sc_xmit_doneH,
  output logic                           xmitH,
  output logic [7:0]                     xmit_dataH,
  input  logic                           xmit_doneH,
  output logic                           readout_done,
  output logic                           busy
);
  import readout_sequencer_verifla_pkg::*;

  localparam int                ADDR_W   = ADDR_OCTETS * 8;
  localparam int                CNT_W    = $clog2(ADDR_OCTETS + 2);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(ADDR_OCTETS);

  state_t             state;
  logic [ADDR_W-1:0]  addr_sr;
  logic [CNT_W-1:0]   octet_cnt;
  logic [CNT_W-1:0]   cnt_inc;

  assign cnt_inc = octet_cnt + 1'b1;

  // NOTE: state and datapath use non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state     <= ST_IDLE;
      addr_sr   <= '0;
      octet_cnt <= '0;
    end else if (baud_clk_posedge) begin
      case (state)
        ST_IDLE: begin
          if (capture_done) begin
            addr_sr   <= ADDR_W'(tail_address);
            octet_cnt <= '0;
            state     <= ST_HDR_SEND;
          end
        end
        ST_HDR_SEND: state <= ST_HDR_WAIT;
        ST_HDR_WAIT: begin
          // Octet 0 is the magic, so the address only shifts after it has sent an address octet.
          if (xmit_doneH) begin
            if (octet_cnt != '0) addr_sr <= addr_sr >> 8;
            octet_cnt <= cnt_inc;
            state     <= (cnt_inc <= CNT_LAST) ? ST_HDR_SEND : ST_SC_START;
          end
        end
        ST_SC_START: if (ack_sc_run) state <= ST_SC_RUN;
        ST_SC_RUN:   if (sc_done) state <= ST_TRL_SEND;
        ST_TRL_SEND: state <= ST_TRL_WAIT;
        ST_TRL_WAIT: if (xmit_doneH) state <= ST_DONE;
        ST_DONE:     state <= ST_WAIT_CLR;
        ST_WAIT_CLR: if (!capture_done) state <= ST_IDLE;
        default:     state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: every output gets a default before the case, so no path leaves one
  // unassigned and no latch is inferred; illegal encodings fall through to all-zero.
  always_comb begin
    sc_run        = 1'b0;
    sc_xmit_doneH = 1'b0;
    xmitH         = 1'b0;
    xmit_dataH    = 8'h00;
    readout_done  = 1'b0;
    busy          = 1'b1;
    case (state)
      ST_IDLE: busy = 1'b0;
      ST_HDR_SEND: begin
        xmitH      = 1'b1;
        xmit_dataH = (octet_cnt == '0) ? HDR_MAGIC : addr_sr[7:0];
      end
      ST_HDR_WAIT: ;
      ST_SC_START: sc_run = 1'b1;
      ST_SC_RUN: begin
        // The capture sender only reaches the UART while it holds the grant.
        xmitH         = sc_xmitH;
        xmit_dataH    = sc_xmit_dataH;
        sc_xmit_doneH = xmit_doneH;
      end
      ST_TRL_SEND: begin
        xmitH      = 1'b1;
        xmit_dataH = TRL_MAGIC;
      end
      ST_TRL_WAIT: ;
      ST_DONE:     readout_done = 1'b1;
      ST_WAIT_CLR: ;
      default:     busy = 1'b0;
    endcase
  end

endmodule
